// File: rtl/wired_inst_buffer_pkg.sv
// Shared types for the decode-to-rename instruction buffer: the decoded
// instruction pack, top-level depth default and a 2-bit popcount helper.
package wired_inst_buffer_pkg;

   localparam int WIRED_IBUF_DEPTH = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [5:0]  uop;
      logic [4:0]  rd;
   } pipeline_ctrl_pack_t;

   function automatic logic [1:0] popcnt2(input logic [1:0] m);
      return {1'b0, m[0]} + {1'b0, m[1]};
   endfunction

endpackage

// File: rtl/wired_inst_buffer_if.sv
// Two-slot instruction packet channel: valid/ready handshake, slot mask, payload.
// Master drives valid/mask/pkg, slave returns ready.
interface wired_inst_buffer_if;
   import wired_inst_buffer_pkg::*;

   logic                      valid;
   logic                      ready;
   logic [1:0]                mask;
   pipeline_ctrl_pack_t [1:0] pkg;

   modport master (output valid, output mask, output pkg, input ready);
   modport slave  (input valid, input mask, input pkg, output ready);

endinterface

// File: rtl/wired_inst_buffer.sv
// Two-wide compacting FIFO between decode and rename; 1-cycle push-to-output latency,
// 0 with WIRED_IBUF_BYPASS_EN on an empty buffer. d_if.ready needs room for two, independent of pops.
module wired_inst_buffer
   import wired_inst_buffer_pkg::*;
#(
   parameter int  DEPTH = WIRED_IBUF_DEPTH,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   wired_inst_buffer_if.slave         d_if,
   wired_inst_buffer_if.master        pkg_if,
   output logic [PTR_W:0]             count_o
);

   localparam int CNT_W = PTR_W + 1;

   pipeline_ctrl_pack_t mem_q [DEPTH];
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic                d_ready;
   logic                push;
   logic [1:0]          n_push;
   logic [1:0]          n_pop;
   logic [1:0]          n_wr;
   logic [1:0]          n_rd;
   logic                pop;
   logic                byp_show;
   logic                byp_hit;
   pipeline_ctrl_pack_t wr_dat0, wr_dat1;
   logic [1:0]          out_mask;
   pipeline_ctrl_pack_t [1:0] out_pkg;

   assign d_ready     = (count_q <= CNT_W'(DEPTH - 2));
   assign d_if.ready  = d_ready;
   assign push        = d_if.valid & d_ready & ~flush_i;
   assign n_push      = push ? popcnt2(d_if.mask) : 2'd0;

   // Compaction: a lone slot-1 instruction lands in the first free entry.
   assign wr_dat0 = (d_if.mask == 2'b10) ? d_if.pkg[1] : d_if.pkg[0];
   assign wr_dat1 = d_if.pkg[1];

`ifdef WIRED_IBUF_BYPASS_EN
   assign byp_show = (count_q == '0) && (n_push != 2'd0);
`else
   assign byp_show = 1'b0;
`endif

   always_comb begin
      out_mask   = (count_q >= CNT_W'(2)) ? 2'b11 :
                   (count_q == CNT_W'(1)) ? 2'b01 : 2'b00;
      out_pkg[0] = mem_q[rd_ptr_q];
      out_pkg[1] = mem_q[rd_ptr_q + PTR_W'(1)];
      if (byp_show) begin
         out_mask = (n_push == 2'd2) ? 2'b11 : 2'b01;
         out_pkg  = {wr_dat1, wr_dat0};
      end
      if (flush_i) begin
         out_mask = 2'b00;
      end
   end

   assign pkg_if.valid = out_mask[0];
   assign pkg_if.mask  = out_mask;
   assign pkg_if.pkg   = out_pkg;

   assign pop     = pkg_if.valid & pkg_if.ready;
   assign n_pop   = pop ? popcnt2(out_mask) : 2'd0;
   // A bypassed packet taken this cycle never touches storage or pointers.
   assign byp_hit = byp_show & pkg_if.ready;
   assign n_wr    = byp_hit ? 2'd0 : n_push;
   assign n_rd    = byp_hit ? 2'd0 : n_pop;

   always_comb begin
      rd_ptr_d = rd_ptr_q + PTR_W'(n_rd);
      wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
      count_d  = count_q + CNT_W'(n_wr) - CNT_W'(n_rd);
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (n_wr != 2'd0) begin
         mem_q[wr_ptr_q] <= wr_dat0;
      end
      if (n_wr == 2'd2) begin
         mem_q[wr_ptr_q + PTR_W'(1)] <= wr_dat1;
      end
   end

   assign count_o = count_q;

   a_count_le_depth: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_W'(DEPTH));
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count_q > CNT_W'(DEPTH - 2))));
   a_mask_never_10: assert property (@(posedge clk) disable iff (!rst_n)
      pkg_if.mask != 2'b10);

endmodule

// File: tb/tb_wired_inst_buffer.sv
// Scoreboard bench for wired_inst_buffer: driver enqueues expected pcs in FIFO
// order, a negedge monitor pops them as the DUT hands out packages.
module tb_wired_inst_buffer;
   import wired_inst_buffer_pkg::*;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush_i;
   logic [3:0] count_o;

   wired_inst_buffer_if d_if ();
   wired_inst_buffer_if pkg_if ();

   wired_inst_buffer #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .d_if    (d_if),
      .pkg_if  (pkg_if),
      .count_o (count_o)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic pipeline_ctrl_pack_t mk(input logic [31:0] pc);
      pipeline_ctrl_pack_t p;
      p.pc   = pc;
      p.inst = ~pc;
      p.uop  = pc[5:0];
      p.rd   = pc[4:0];
      return p;
   endfunction

   // One cycle of stimulus; count_o / d_ready are checked against the scoreboard depth.
   task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] base,
                        input logic rdy, input logic fl);
      int occ;
      @(posedge clk);
      #1;
      occ = sb.size();
      chk("count", 32'(count_o), 32'(occ));
      chk("d_ready", 32'(d_if.ready), 32'(occ <= DEPTH - 2));
      d_if.valid   = v;
      d_if.mask    = m;
      d_if.pkg[0]  = mk(base);
      d_if.pkg[1]  = mk(base + 1);
      pkg_if.ready = rdy;
      flush_i      = fl;
      if (fl) begin
         sb.delete();
      end else if (v && occ <= DEPTH - 2) begin
         if (m[0]) sb.push_back(base);
         if (m[1]) sb.push_back(base + 1);
      end
   endtask

   // Monitor: pops on accepted packages and checks that stalled packages stay put.
   logic        hold_vld = 1'b0;
   logic [31:0] hold_pc0 = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_vld = 1'b0;
      end else begin
         chk("mask_not_10", 32'(pkg_if.mask == 2'b10), 32'd0);
         if (hold_vld && !flush_i) begin
            chk("hold_valid", 32'(pkg_if.valid), 32'd1);
            chk("hold_pc0", pkg_if.pkg[0].pc, hold_pc0);
         end
         if (pkg_if.valid && pkg_if.ready) begin
            for (int s = 0; s < 2; s++) begin
               if (pkg_if.mask[s]) begin
                  if (sb.size() == 0) begin
                     chk("sb_underflow", pkg_if.pkg[s].pc, 32'hdead_beef);
                  end else begin
                     chk("out_pc", pkg_if.pkg[s].pc, sb.pop_front());
                  end
               end
            end
         end
         hold_vld = pkg_if.valid && !pkg_if.ready;
         hold_pc0 = pkg_if.pkg[0].pc;
      end
   end

   initial begin
      rst_n        = 1'b0;
      flush_i      = 1'b0;
      d_if.valid   = 1'b0;
      d_if.mask    = 2'b00;
      d_if.pkg     = '0;
      pkg_if.ready = 1'b0;
      #3;
      chk("rst_valid", 32'(pkg_if.valid), 32'd0);
      chk("rst_mask", 32'(pkg_if.mask), 32'd0);
      chk("rst_d_ready", 32'(d_if.ready), 32'd1);
      chk("rst_count", 32'(count_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill to DEPTH with the backend stalled.
      for (int i = 0; i < 4; i++) drive(1'b1, 2'b11, 32'h100 + 32'(2 * i), 1'b0, 1'b0);
      drive(1'b1, 2'b11, 32'h1f0, 1'b0, 1'b0);
      @(negedge clk);
      chk("full_mask", 32'(pkg_if.mask), 32'd3);
      chk("full_pc0", pkg_if.pkg[0].pc, 32'h100);
      chk("full_pc1", pkg_if.pkg[1].pc, 32'h101);
      for (int i = 0; i < 5; i++) drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);

      // Compaction of masks 10, 01, 11 while draining.
      drive(1'b1, 2'b10, 32'h200, 1'b1, 1'b0);
      drive(1'b1, 2'b01, 32'h210, 1'b1, 1'b0);
      drive(1'b1, 2'b11, 32'h220, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);

      // count=6 with 2-in/2-out, then count=7 blocks input even while popping.
      for (int i = 0; i < 3; i++) drive(1'b1, 2'b11, 32'h300 + 32'(2 * i), 1'b0, 1'b0);
      drive(1'b1, 2'b11, 32'h310, 1'b1, 1'b0);
      drive(1'b1, 2'b01, 32'h320, 1'b0, 1'b0);
      drive(1'b1, 2'b11, 32'h330, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);

      // Flush at count=5 with a valid packet that must vanish.
      drive(1'b1, 2'b11, 32'h400, 1'b0, 1'b0);
      drive(1'b1, 2'b11, 32'h402, 1'b0, 1'b0);
      drive(1'b1, 2'b01, 32'h404, 1'b0, 1'b0);
      drive(1'b1, 2'b11, 32'h4f0, 1'b1, 1'b1);
      @(negedge clk);
      chk("flush_valid", 32'(pkg_if.valid), 32'd0);
      for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);

      // Random traffic crossing the pointer wrap.
      for (int i = 0; i < 20; i++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               32'h500 + 32'(2 * i), 1'($urandom_range(0, 1)), 1'b0);
      end
      for (int i = 0; i < 6; i++) drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between clock edges.
      drive(1'b1, 2'b11, 32'h600, 1'b0, 1'b0);
      drive(1'b1, 2'b11, 32'h602, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      d_if.valid = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk("arst_valid", 32'(pkg_if.valid), 32'd0);
      chk("arst_count", 32'(count_o), 32'd0);
      sb.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      // Push into an empty buffer with the backend ready.
      drive(1'b1, 2'b11, 32'h700, 1'b1, 1'b0);
      @(negedge clk);
`ifdef WIRED_IBUF_BYPASS_EN
      chk("byp_mask", 32'(pkg_if.mask), 32'd3);
`else
      chk("lat_valid", 32'(pkg_if.valid), 32'd0);
`endif
      for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
